// File: rtl/phoenix_input.sv
// phoenix_input: maps PS/2 keyboard events and a merged joystick word onto
// the Phoenix arcade control inputs, and shapes a fixed-length coin pulse.
//
// Ports
//   clk_sys          in   system clock, the only clock in the block
//   reset_n          in   synchronous active-low reset
//   ps2_key[10:0]    in   [10] toggle, [9] pressed, [8] extended, [7:0] code
//   joy[15:0]        in   [0] R [1] L [2] D [3] U [4] fire [5] barrier
//                         [6] start1 [7] start2 [8] coin, [15:9] unused
//   rotate           in   1 = horizontal cabinet (up/down steer the ship)
//   btn_left         out  registered left control
//   btn_right        out  registered right control
//   btn_fire         out  registered fire control
//   btn_barrier      out  registered barrier control
//   btn_player_start out  [0] 1P start, [1] 2P start
//   btn_coin         out  COIN_LEN-cycle coin pulse
//
// Coin FSM
//   state    | meaning
//   ST_IDLE  | waiting for a rising edge of coin_req
//   ST_PULSE | btn_coin high, counting COIN_LEN cycles
//   ST_GAP   | btn_coin low, counting COIN_GAP cycles; new edges discarded
module phoenix_input #(
  parameter logic [23:0] COIN_LEN = 24'd1100000,
  parameter logic [23:0] COIN_GAP = 24'd1100000
) (
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic [10:0] ps2_key,
  input  logic [15:0] joy,
  input  logic        rotate,
  output logic        btn_left,
  output logic        btn_right,
  output logic        btn_fire,
  output logic        btn_barrier,
  output logic [1:0]  btn_player_start,
  output logic        btn_coin
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_PULSE = 2'd1;
  localparam logic [1:0] ST_GAP   = 2'd2;

  logic       r_tog_q;
  logic       r_up, r_down, r_left, r_right, r_fire, r_barrier;
  logic       r_up2, r_down2, r_left2, r_right2, r_fire2, r_barrier2;
  logic       r_start1, r_start2, r_coin;
  logic       r_btn_left, r_btn_right, r_btn_fire, r_btn_barrier;
  logic [1:0] r_btn_start;
  logic       r_btn_coin;
  logic [1:0] r_state;
  logic [23:0] r_cnt;
  logic       r_coin_req_q;

  logic w_event, w_pressed, w_ext;
  logic w_left_sel, w_right_sel;
  logic w_coin_req, w_coin_rise;
  logic w_unused_joy;

  assign w_event   = ps2_key[10] != r_tog_q;
  assign w_pressed = ps2_key[9];
  assign w_ext     = ps2_key[8];
  assign w_unused_joy = ^joy[15:9];

  // Toggle tracker keeps loading during reset so the first cycle after
  // release cannot see a stale toggle as an event.
  always_ff @(posedge clk_sys) begin
    r_tog_q <= ps2_key[10];
  end

  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      r_up <= 1'b0;  r_down <= 1'b0;  r_left <= 1'b0;  r_right <= 1'b0;
      r_fire <= 1'b0;  r_barrier <= 1'b0;
      r_up2 <= 1'b0; r_down2 <= 1'b0; r_left2 <= 1'b0; r_right2 <= 1'b0;
      r_fire2 <= 1'b0; r_barrier2 <= 1'b0;
      r_start1 <= 1'b0; r_start2 <= 1'b0; r_coin <= 1'b0;
    end else if (w_event) begin
      case (ps2_key[7:0])
        // arrow keys and barrier accept either extended state
        8'h75: r_up      <= w_pressed;
        8'h72: r_down    <= w_pressed;
        8'h6B: r_left    <= w_pressed;
        8'h74: r_right   <= w_pressed;
        8'h14: r_barrier <= w_pressed;
        // the rest are plain (non-extended) keys only
        8'h29: if (!w_ext) r_fire     <= w_pressed;
        8'h05,
        8'h16: if (!w_ext) r_start1   <= w_pressed;
        8'h06,
        8'h1E: if (!w_ext) r_start2   <= w_pressed;
        8'h2E,
        8'h36: if (!w_ext) r_coin     <= w_pressed;
        8'h2D: if (!w_ext) r_up2      <= w_pressed;
        8'h2B: if (!w_ext) r_down2    <= w_pressed;
        8'h23: if (!w_ext) r_left2    <= w_pressed;
        8'h34: if (!w_ext) r_right2   <= w_pressed;
        8'h1C: if (!w_ext) r_fire2    <= w_pressed;
        8'h1B: if (!w_ext) r_barrier2 <= w_pressed;
        default: ;
      endcase
    end
  end

  // In the horizontal cabinet the ship steers with down/up.
  assign w_left_sel  = rotate ? (r_down | r_down2 | joy[2]) : (r_left  | r_left2  | joy[1]);
  assign w_right_sel = rotate ? (r_up   | r_up2   | joy[3]) : (r_right | r_right2 | joy[0]);

  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      r_btn_left    <= 1'b0;
      r_btn_right   <= 1'b0;
      r_btn_fire    <= 1'b0;
      r_btn_barrier <= 1'b0;
      r_btn_start   <= 2'b00;
    end else begin
      r_btn_left    <= w_left_sel;
      r_btn_right   <= w_right_sel;
      r_btn_fire    <= r_fire | r_fire2 | joy[4];
      r_btn_barrier <= r_barrier | r_barrier2 | joy[5];
      r_btn_start   <= {r_start2 | joy[7], r_start1 | joy[6]};
    end
  end

  // Pressing a start key also inserts a coin.
  assign w_coin_req  = r_start1 | r_start2 | r_coin | joy[6] | joy[7] | joy[8];
  assign w_coin_rise = w_coin_req & ~r_coin_req_q;

  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      r_state      <= ST_IDLE;
      r_cnt        <= 24'd0;
      r_coin_req_q <= 1'b0;
      r_btn_coin   <= 1'b0;
    end else begin
      r_coin_req_q <= w_coin_req;
      case (r_state)
        ST_IDLE: begin
          if (w_coin_rise) begin
            r_state    <= ST_PULSE;
            r_cnt      <= COIN_LEN - 24'd1;
            r_btn_coin <= 1'b1;
          end
        end
        ST_PULSE: begin
          if (r_cnt == 24'd0) begin
            r_state    <= ST_GAP;
            r_cnt      <= COIN_GAP - 24'd1;
            r_btn_coin <= 1'b0;
          end else begin
            r_cnt <= r_cnt - 24'd1;
          end
        end
        ST_GAP: begin
          if (r_cnt == 24'd0) begin
            r_state <= ST_IDLE;
          end else begin
            r_cnt <= r_cnt - 24'd1;
          end
        end
        default: begin
          r_state    <= ST_IDLE;
          r_cnt      <= 24'd0;
          r_btn_coin <= 1'b0;
        end
      endcase
    end
  end

  assign btn_left         = r_btn_left;
  assign btn_right        = r_btn_right;
  assign btn_fire         = r_btn_fire;
  assign btn_barrier      = r_btn_barrier;
  assign btn_player_start = r_btn_start;
  assign btn_coin         = r_btn_coin;

endmodule

// File: tb/tb_phoenix_input.sv
// Bench for phoenix_input with COIN_LEN=4, COIN_GAP=3.
// Outputs are viewed as {coin, start[1:0], barrier, fire, right, left}.
module tb_phoenix_input;

  logic        clk_sys = 1'b0;
  logic        reset_n;
  logic [10:0] ps2_key;
  logic [15:0] joy;
  logic        rotate;
  logic        btn_left, btn_right, btn_fire, btn_barrier, btn_coin;
  logic [1:0]  btn_player_start;
  logic [6:0]  outs;

  always #5 clk_sys = ~clk_sys;

  phoenix_input #(.COIN_LEN(24'd4), .COIN_GAP(24'd3)) dut (
    .clk_sys(clk_sys), .reset_n(reset_n), .ps2_key(ps2_key), .joy(joy),
    .rotate(rotate), .btn_left(btn_left), .btn_right(btn_right),
    .btn_fire(btn_fire), .btn_barrier(btn_barrier),
    .btn_player_start(btn_player_start), .btn_coin(btn_coin)
  );

  assign outs = {btn_coin, btn_player_start, btn_barrier, btn_fire, btn_right, btn_left};

  int checks = 0;
  int errors = 0;

  typedef struct {
    string      name;
    logic [6:0] mask;
    logic [6:0] exp;
  } sb_t;
  sb_t sbq[$];

  typedef struct {
    logic        rot;
    logic [15:0] joy;
    logic        kv;
    logic        pr;
    logic        ex;
    logic [7:0]  code;
    logic [6:0]  exp;
  } vec_t;
  vec_t vecs[24];

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic expect_out(input string n, input logic [6:0] m, input logic [6:0] e);
    sb_t s;
    s.name = n; s.mask = m; s.exp = e;
    sbq.push_back(s);
  endtask

  task automatic compare();
    sb_t s;
    checks++;
    if (sbq.size() == 0) begin
      errors++;
      $display("FAIL scoreboard_empty: no expected entry for actual %b", outs);
    end else begin
      s = sbq.pop_front();
      if ((outs & s.mask) !== (s.exp & s.mask)) begin
        errors++;
        $display("FAIL %s: actual %b required %b (mask %b)", s.name, outs, s.exp, s.mask);
      end
    end
  endtask

  task automatic send_key(input logic pr, input logic ex, input logic [7:0] code);
    ps2_key = {~ps2_key[10], pr, ex, code};
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    //          rot  joy        kv    pr    ex    code   expected
    vecs[0]  = '{1'b0, 16'h0000, 1'b1, 1'b1, 1'b1, 8'h6B, 7'b0000001};
    vecs[1]  = '{1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 8'h6B, 7'b0000000};
    vecs[2]  = '{1'b0, 16'h0000, 1'b1, 1'b1, 1'b1, 8'h29, 7'b0000000};
    vecs[3]  = '{1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 8'h29, 7'b0000100};
    vecs[4]  = '{1'b0, 16'h0020, 1'b0, 1'b0, 1'b0, 8'h00, 7'b0001100};
    vecs[5]  = '{1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 8'h29, 7'b0000000};
    vecs[6]  = '{1'b1, 16'h0000, 1'b1, 1'b1, 1'b0, 8'h75, 7'b0000010};
    vecs[7]  = '{1'b1, 16'h0000, 1'b1, 1'b1, 1'b0, 8'h6B, 7'b0000010};
    vecs[8]  = '{1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 8'h00, 7'b0000001};
    vecs[9]  = '{1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 8'h34, 7'b0000011};
    vecs[10] = '{1'b1, 16'h0004, 1'b0, 1'b0, 1'b0, 8'h00, 7'b0000011};
    vecs[11] = '{1'b1, 16'h0000, 1'b1, 1'b1, 1'b1, 8'h72, 7'b0000011};
    vecs[12] = '{1'b1, 16'h0000, 1'b1, 1'b0, 1'b1, 8'h75, 7'b0000001};
    vecs[13] = '{1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 8'h6B, 7'b0000010};
    vecs[14] = '{1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 8'h34, 7'b0000000};
    vecs[15] = '{1'b1, 16'h0000, 1'b1, 1'b1, 1'b0, 8'h11, 7'b0000001};
    vecs[16] = '{1'b1, 16'h0000, 1'b1, 1'b0, 1'b0, 8'h72, 7'b0000000};
    vecs[17] = '{1'b0, 16'hFE00, 1'b0, 1'b0, 1'b0, 8'h00, 7'b0000000};
    vecs[18] = '{1'b1, 16'h0008, 1'b0, 1'b0, 1'b0, 8'h00, 7'b0000010};
    vecs[19] = '{1'b0, 16'h0003, 1'b0, 1'b0, 1'b0, 8'h00, 7'b0000011};
    vecs[20] = '{1'b0, 16'h0000, 1'b1, 1'b1, 1'b1, 8'h14, 7'b0001000};
    vecs[21] = '{1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 8'h14, 7'b0000000};
    vecs[22] = '{1'b0, 16'h0010, 1'b0, 1'b0, 1'b0, 8'h00, 7'b0000100};
    vecs[23] = '{1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 8'h00, 7'b0000000};

    reset_n = 1'b0; ps2_key = 11'd0; joy = 16'h0000; rotate = 1'b0;
    tick(); tick();
    expect_out("reset_outputs", 7'h7F, 7'h00); compare();
    reset_n = 1'b1;
    tick();
    expect_out("post_reset_idle", 7'h7F, 7'h00); compare();

    // Key/joystick mapping: one event per vector, checked two edges later.
    for (int i = 0; i < 24; i++) begin
      rotate = vecs[i].rot;
      joy    = vecs[i].joy;
      if (vecs[i].kv) send_key(vecs[i].pr, vecs[i].ex, vecs[i].code);
      expect_out($sformatf("vec%0d", i), 7'h7F, vecs[i].exp);
      tick(); tick();
      compare();
    end

    // Press and release on consecutive edges: one cycle of fire, then low.
    send_key(1'b1, 1'b0, 8'h1C);
    tick();
    send_key(1'b0, 1'b0, 8'h1C);
    expect_out("back_to_back_press", 7'h7F, 7'b0000100);
    tick(); compare();
    expect_out("back_to_back_release", 7'h7F, 7'b0000000);
    tick(); compare();

    // Coin pulse length, discard during GAP, acceptance after GAP.
    joy = 16'h0100;
    for (int k = 0; k < 18; k++) begin
      expect_out($sformatf("coin_seq_k%0d", k), 7'h40,
                 ((k <= 3) || (k >= 9 && k <= 12)) ? 7'h40 : 7'h00);
      tick(); compare();
      joy = (k == 4 || k == 8) ? 16'h0100 : 16'h0000;
    end

    // Held start1 key: start stays asserted, one coin pulse only.
    send_key(1'b1, 1'b0, 8'h16);
    for (int k = 0; k < 16; k++) begin
      expect_out($sformatf("start1_hold_k%0d", k), 7'h7F,
                 {(k >= 1 && k <= 4) ? 1'b1 : 1'b0, (k >= 1) ? 2'b01 : 2'b00, 4'b0000});
      tick(); compare();
    end
    send_key(1'b0, 1'b0, 8'h16);
    tick(); tick();
    expect_out("start1_release", 7'h7F, 7'h00); compare();

    // Reset during the second PULSE cycle aborts the pulse and clears latches.
    send_key(1'b1, 1'b0, 8'h29);
    tick(); tick();
    expect_out("fire_before_reset", 7'h7F, 7'b0000100); compare();
    joy = 16'h0100;
    expect_out("pulse_cycle1", 7'h7F, 7'b1000100);
    tick(); compare();
    joy = 16'h0000;
    expect_out("pulse_cycle2", 7'h7F, 7'b1000100);
    tick(); compare();
    reset_n = 1'b0;
    expect_out("reset_aborts_pulse", 7'h7F, 7'h00);
    tick(); compare();
    tick();
    reset_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      expect_out($sformatf("after_abort_k%0d", k), 7'h7F, 7'h00);
      tick(); compare();
    end

    // Toggle during reset must not appear as an event after release.
    reset_n = 1'b0;
    tick();
    ps2_key = {~ps2_key[10], 1'b1, 1'b0, 8'h6B};
    tick();
    reset_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      expect_out($sformatf("toggle_in_reset_k%0d", k), 7'h7F, 7'h00);
      tick(); compare();
    end

    // Coin request held across reset release: exactly one pulse.
    reset_n = 1'b0;
    joy = 16'h0100;
    tick(); tick();
    reset_n = 1'b1;
    for (int k = 0; k < 12; k++) begin
      expect_out($sformatf("held_across_reset_k%0d", k), 7'h40, (k <= 3) ? 7'h40 : 7'h00);
      tick(); compare();
    end
    joy = 16'h0000;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
